// File: rtl/packet_dispatcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : packet_dispatcher_pkg                                      |
// | Description : Shared FSM state encodings and helpers for the dispatcher. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package packet_dispatcher_pkg;

   typedef enum logic [1:0] {
      SN_IDLE  = 2'd0,
      SN_OFFER = 2'd1,
      SN_BUSY  = 2'd2
   } sn_state_t;

   typedef enum logic [1:0] {
      FW_IDLE  = 2'd0,
      FW_OFFER = 2'd1,
      FW_BUSY  = 2'd2
   } fw_state_t;

   // Round-robin successor of an index in 0..n-1.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/packet_dispatcher_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : packet_dispatcher_rr_picker                                |
// | Description : Round-robin picker: first set request at/after pointer.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module packet_dispatcher_rr_picker
   import packet_dispatcher_pkg::*;
#(
   parameter int N_REQ = 4
)(
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic                     o_valid,
   output logic [$clog2(N_REQ)-1:0] o_idx
);

   localparam int c_idx_w = $clog2(N_REQ);
   localparam int c_sum_w = c_idx_w + 1;

   logic [N_REQ-1:0]   w_rot;
   logic [c_sum_w-1:0] w_sum;

   // Rotate so bit 0 is the request sitting at the pointer.
   assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

   always_comb begin
      o_valid = 1'b0;
      w_sum   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (|(w_rot & (N_REQ'(1) << i))) begin
            o_valid = 1'b1;
            w_sum   = {1'b0, i_ptr} + c_sum_w'(i);
         end
      end
      o_idx = (w_sum >= c_sum_w'(N_REQ)) ? c_idx_w'(w_sum - c_sum_w'(N_REQ))
                                         : c_idx_w'(w_sum);
   end

endmodule
`default_nettype wire

// File: rtl/packet_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : packet_dispatcher                                          |
// | Description : Routes snooper and forwarder to packetfilter cores, RR.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module packet_dispatcher
   import packet_dispatcher_pkg::*;
#(
   parameter int N_CORES           = 4,
   parameter int SN_FWD_DATA_WIDTH = 64,
   parameter int PLEN_WIDTH        = 32
)(
   input  logic                                   clk,
   input  logic                                   rst,
   output logic                                   rdy_for_sn,
   input  logic                                   rdy_for_sn_ack,
   input  logic                                   sn_wr_en,
   input  logic                                   sn_done,
   input  logic [N_CORES-1:0]                     core_rdy_for_sn,
   output logic [N_CORES-1:0]                     core_rdy_for_sn_ack,
   output logic [N_CORES-1:0]                     core_sn_wr_en,
   output logic [N_CORES-1:0]                     core_sn_done,
   output logic                                   rdy_for_fwd,
   input  logic                                   rdy_for_fwd_ack,
   input  logic                                   fwd_rd_en,
   input  logic                                   fwd_done,
   input  logic [N_CORES-1:0]                     core_rdy_for_fwd,
   output logic [N_CORES-1:0]                     core_rdy_for_fwd_ack,
   output logic [N_CORES-1:0]                     core_fwd_rd_en,
   output logic [N_CORES-1:0]                     core_fwd_done,
   input  logic [N_CORES*SN_FWD_DATA_WIDTH-1:0]   core_fwd_rd_data,
   input  logic [N_CORES-1:0]                     core_fwd_rd_data_vld,
   input  logic [N_CORES*PLEN_WIDTH-1:0]          core_fwd_byte_len,
   output logic [SN_FWD_DATA_WIDTH-1:0]           fwd_rd_data,
   output logic                                   fwd_rd_data_vld,
   output logic [PLEN_WIDTH-1:0]                  fwd_byte_len,
   output logic [$clog2(N_CORES)-1:0]             sn_sel,
   output logic [$clog2(N_CORES)-1:0]             fwd_sel
);

   localparam int c_sel_w = $clog2(N_CORES);

   sn_state_t          r_sn_state, w_sn_state_nxt;
   logic [c_sel_w-1:0] r_sn_sel, w_sn_sel_nxt, r_sn_ptr, w_sn_ptr_nxt;
   logic               w_sn_pick_vld;
   logic [c_sel_w-1:0] w_sn_pick_idx;

   fw_state_t          r_fw_state, w_fw_state_nxt;
   logic [c_sel_w-1:0] r_fw_sel, w_fw_sel_nxt, r_fw_ptr, w_fw_ptr_nxt;
   logic               w_fw_pick_vld;
   logic [c_sel_w-1:0] w_fw_pick_idx;

   logic [SN_FWD_DATA_WIDTH-1:0] w_core_data [N_CORES];
   logic [PLEN_WIDTH-1:0]        w_core_len  [N_CORES];

   generate
      for (genvar g = 0; g < N_CORES; g++) begin : g_core_slice
         assign w_core_data[g] = core_fwd_rd_data[g*SN_FWD_DATA_WIDTH +: SN_FWD_DATA_WIDTH];
         assign w_core_len[g]  = core_fwd_byte_len[g*PLEN_WIDTH +: PLEN_WIDTH];
      end
   endgenerate

   packet_dispatcher_rr_picker #(.N_REQ(N_CORES)) u_sn_pick (
      .i_req   (core_rdy_for_sn),
      .i_ptr   (r_sn_ptr),
      .o_valid (w_sn_pick_vld),
      .o_idx   (w_sn_pick_idx)
   );

   packet_dispatcher_rr_picker #(.N_REQ(N_CORES)) u_fw_pick (
      .i_req   (core_rdy_for_fwd),
      .i_ptr   (r_fw_ptr),
      .o_valid (w_fw_pick_vld),
      .o_idx   (w_fw_pick_idx)
   );

   assign sn_sel      = r_sn_sel;
   assign fwd_sel     = r_fw_sel;
   assign rdy_for_sn  = (r_sn_state == SN_OFFER);
   assign rdy_for_fwd = (r_fw_state == FW_OFFER);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sn_state <= SN_IDLE;
         r_sn_sel   <= '0;
         r_sn_ptr   <= '0;
         r_fw_state <= FW_IDLE;
         r_fw_sel   <= '0;
         r_fw_ptr   <= '0;
      end else begin
         r_sn_state <= w_sn_state_nxt;
         r_sn_sel   <= w_sn_sel_nxt;
         r_sn_ptr   <= w_sn_ptr_nxt;
         r_fw_state <= w_fw_state_nxt;
         r_fw_sel   <= w_fw_sel_nxt;
         r_fw_ptr   <= w_fw_ptr_nxt;
      end
   end

   always_comb begin
      w_sn_state_nxt      = r_sn_state;
      w_sn_sel_nxt        = r_sn_sel;
      w_sn_ptr_nxt        = r_sn_ptr;
      core_rdy_for_sn_ack = '0;
      core_sn_wr_en       = '0;
      core_sn_done        = '0;
      case (r_sn_state)
         SN_IDLE: begin
            if (w_sn_pick_vld) begin
               w_sn_sel_nxt   = w_sn_pick_idx;
               w_sn_state_nxt = SN_OFFER;
            end
         end
         SN_OFFER: begin
            // A withdrawn core wins over a simultaneous ack; pointer stays put.
            if (!core_rdy_for_sn[r_sn_sel]) begin
               w_sn_state_nxt = SN_IDLE;
            end else if (rdy_for_sn_ack) begin
               core_rdy_for_sn_ack[r_sn_sel] = 1'b1;
               w_sn_state_nxt                = SN_BUSY;
            end
         end
         SN_BUSY: begin
            core_sn_wr_en[r_sn_sel] = sn_wr_en;
            core_sn_done[r_sn_sel]  = sn_done;
            if (sn_done) begin
               w_sn_ptr_nxt   = c_sel_w'(wrap_inc(32'(r_sn_sel), N_CORES));
               w_sn_state_nxt = SN_IDLE;
            end
         end
         default: w_sn_state_nxt = SN_IDLE;
      endcase
   end

   always_comb begin
      w_fw_state_nxt       = r_fw_state;
      w_fw_sel_nxt         = r_fw_sel;
      w_fw_ptr_nxt         = r_fw_ptr;
      core_rdy_for_fwd_ack = '0;
      core_fwd_rd_en       = '0;
      core_fwd_done        = '0;
      fwd_rd_data          = '0;
      fwd_rd_data_vld      = 1'b0;
      fwd_byte_len         = '0;
      case (r_fw_state)
         FW_IDLE: begin
            if (w_fw_pick_vld) begin
               w_fw_sel_nxt   = w_fw_pick_idx;
               w_fw_state_nxt = FW_OFFER;
            end
         end
         FW_OFFER: begin
            if (!core_rdy_for_fwd[r_fw_sel]) begin
               w_fw_state_nxt = FW_IDLE;
            end else if (rdy_for_fwd_ack) begin
               core_rdy_for_fwd_ack[r_fw_sel] = 1'b1;
               w_fw_state_nxt                 = FW_BUSY;
            end
         end
         FW_BUSY: begin
            core_fwd_rd_en[r_fw_sel] = fwd_rd_en;
            core_fwd_done[r_fw_sel]  = fwd_done;
            fwd_rd_data              = w_core_data[r_fw_sel];
            fwd_rd_data_vld          = core_fwd_rd_data_vld[r_fw_sel];
            fwd_byte_len             = w_core_len[r_fw_sel];
            if (fwd_done) begin
               w_fw_ptr_nxt   = c_sel_w'(wrap_inc(32'(r_fw_sel), N_CORES));
               w_fw_state_nxt = FW_IDLE;
            end
         end
         default: w_fw_state_nxt = FW_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_packet_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_packet_dispatcher                                       |
// | Description : Directed and random checks against a transaction model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_packet_dispatcher;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int LW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rdy_for_sn, rdy_for_sn_ack, sn_wr_en, sn_done;
   logic [N-1:0]  core_rdy_for_sn, core_rdy_for_sn_ack, core_sn_wr_en, core_sn_done;
   logic          rdy_for_fwd, rdy_for_fwd_ack, fwd_rd_en, fwd_done;
   logic [N-1:0]  core_rdy_for_fwd, core_rdy_for_fwd_ack, core_fwd_rd_en, core_fwd_done;
   logic [N*DW-1:0] core_fwd_rd_data;
   logic [N-1:0]  core_fwd_rd_data_vld;
   logic [N*LW-1:0] core_fwd_byte_len;
   logic [DW-1:0] fwd_rd_data;
   logic          fwd_rd_data_vld;
   logic [LW-1:0] fwd_byte_len;
   logic [1:0]    sn_sel, fwd_sel;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   packet_dispatcher #(.N_CORES(N), .SN_FWD_DATA_WIDTH(DW), .PLEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .rdy_for_sn(rdy_for_sn), .rdy_for_sn_ack(rdy_for_sn_ack),
      .sn_wr_en(sn_wr_en), .sn_done(sn_done),
      .core_rdy_for_sn(core_rdy_for_sn), .core_rdy_for_sn_ack(core_rdy_for_sn_ack),
      .core_sn_wr_en(core_sn_wr_en), .core_sn_done(core_sn_done),
      .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
      .fwd_rd_en(fwd_rd_en), .fwd_done(fwd_done),
      .core_rdy_for_fwd(core_rdy_for_fwd), .core_rdy_for_fwd_ack(core_rdy_for_fwd_ack),
      .core_fwd_rd_en(core_fwd_rd_en), .core_fwd_done(core_fwd_done),
      .core_fwd_rd_data(core_fwd_rd_data), .core_fwd_rd_data_vld(core_fwd_rd_data_vld),
      .core_fwd_byte_len(core_fwd_byte_len),
      .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld),
      .fwd_byte_len(fwd_byte_len), .sn_sel(sn_sel), .fwd_sel(fwd_sel)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      return |(v & (N'(1) << i));
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return (i < 0) ? '0 : (N'(1) << i);
   endfunction

   // Transaction model per side (0 = snoop, 1 = forward): which core is
   // currently offered, which one owns the transfer, where the next search starts.
   int m_offer [2] = '{-1, -1};
   int m_busy  [2] = '{-1, -1};
   int m_ptr   [2] = '{0, 0};
   int m_sel   [2] = '{0, 0};

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++)
         if (bit_of(r, (ptr + k) % N)) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_step(input int s, input logic [N-1:0] r, input logic ack, input logic done);
      int c;
      if (m_busy[s] >= 0) begin
         if (done) begin
            m_ptr[s]  = (m_busy[s] + 1) % N;
            m_busy[s] = -1;
         end
      end else if (m_offer[s] >= 0) begin
         if (!bit_of(r, m_offer[s])) m_offer[s] = -1;
         else if (ack) begin
            m_busy[s]  = m_offer[s];
            m_offer[s] = -1;
         end
      end else begin
         c = pick(r, m_ptr[s]);
         if (c >= 0) begin
            m_offer[s] = c;
            m_sel[s]   = c;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            m_offer[s] = -1; m_busy[s] = -1; m_ptr[s] = 0; m_sel[s] = 0;
         end
      end else begin
         model_step(0, core_rdy_for_sn, rdy_for_sn_ack, sn_done);
         model_step(1, core_rdy_for_fwd, rdy_for_fwd_ack, fwd_done);
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] e_data;
      logic [LW-1:0] e_len;
      logic          e_vld;
      chk("m_sn_rdy", rdy_for_sn, m_offer[0] >= 0);
      chk("m_sn_sel", sn_sel, m_sel[0]);
      chk("m_sn_ack", core_rdy_for_sn_ack,
          (m_offer[0] >= 0 && rdy_for_sn_ack && bit_of(core_rdy_for_sn, m_offer[0])) ? onehot(m_offer[0]) : '0);
      chk("m_sn_wr", core_sn_wr_en, sn_wr_en ? onehot(m_busy[0]) : '0);
      chk("m_sn_done", core_sn_done, sn_done ? onehot(m_busy[0]) : '0);
      chk("m_fw_rdy", rdy_for_fwd, m_offer[1] >= 0);
      chk("m_fw_sel", fwd_sel, m_sel[1]);
      chk("m_fw_ack", core_rdy_for_fwd_ack,
          (m_offer[1] >= 0 && rdy_for_fwd_ack && bit_of(core_rdy_for_fwd, m_offer[1])) ? onehot(m_offer[1]) : '0);
      chk("m_fw_rd", core_fwd_rd_en, fwd_rd_en ? onehot(m_busy[1]) : '0);
      chk("m_fw_done", core_fwd_done, fwd_done ? onehot(m_busy[1]) : '0);
      e_data = '0; e_len = '0; e_vld = 1'b0;
      if (m_busy[1] >= 0) begin
         e_data = core_fwd_rd_data[m_busy[1]*DW +: DW];
         e_len  = core_fwd_byte_len[m_busy[1]*LW +: LW];
         e_vld  = bit_of(core_fwd_rd_data_vld, m_busy[1]);
      end
      chk("m_fw_data", fwd_rd_data, e_data);
      chk("m_fw_len", fwd_byte_len, e_len);
      chk("m_fw_vld", fwd_rd_data_vld, e_vld);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rdy_for_sn_ack = 0; sn_wr_en = 0; sn_done = 0; core_rdy_for_sn = '0;
      rdy_for_fwd_ack = 0; fwd_rd_en = 0; fwd_done = 0; core_rdy_for_fwd = '0;
      core_fwd_rd_data_vld = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // One complete snoop packet; the expected routing mask is supplied by the caller.
   task automatic sn_packet(input int nwr, input logic [N-1:0] exp_mask, output int sel);
      for (int k = 0; k < 20 && !rdy_for_sn; k++) step();
      chk("sn_offer_seen", rdy_for_sn, 1);
      sel = int'(sn_sel);
      rdy_for_sn_ack = 1;
      #1;
      chk("sn_pkt_ack", core_rdy_for_sn_ack, exp_mask);
      step();
      rdy_for_sn_ack = 0;
      for (int k = 0; k < nwr; k++) begin
         sn_wr_en = 1;
         #1;
         chk("sn_pkt_wr", core_sn_wr_en, exp_mask);
         step();
      end
      sn_wr_en = 0;
      sn_done  = 1;
      #1;
      chk("sn_pkt_done", core_sn_done, exp_mask);
      step();
      sn_done = 0;
   endtask

   initial begin
      int sel;
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] flip;

      clear_inputs();
      core_fwd_rd_data  = '0;
      core_fwd_byte_len = '0;
      #1 rst = 1'b1;
      step();
      step();
      chk("rst_rdy_sn", rdy_for_sn, 0);
      chk("rst_rdy_fwd", rdy_for_fwd, 0);
      chk("rst_sn_sel", sn_sel, 0);
      chk("rst_fwd_sel", fwd_sel, 0);
      chk("rst_vld", fwd_rd_data_vld, 0);
      rst = 1'b0;

      // Single request: offered one cycle later, ack routed to core 0.
      core_rdy_for_sn = 4'b0001;
      step();
      chk("t1_offer", rdy_for_sn, 1);
      chk("t1_sel", sn_sel, 0);
      rdy_for_sn_ack = 1;
      #1;
      chk("t1_ack", core_rdy_for_sn_ack, 4'b0001);
      step();
      rdy_for_sn_ack = 0;
      #1;
      chk("t1_ack_once", core_rdy_for_sn_ack, 4'b0000);
      sn_done = 1;
      step();
      sn_done = 0;
      core_rdy_for_sn = '0;

      // Round-robin order with all cores requesting.
      do_reset();
      core_rdy_for_sn = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         sn_packet(1, 4'b0001 << exp_seq[i], sel);
         chk("rr_seq", sel, exp_seq[i]);
      end

      // Writes routed only to core 2; pointer then lands on 3.
      do_reset();
      core_rdy_for_sn = 4'b0100;
      sn_packet(8, 4'b0100, sel);
      chk("t3_sel", sel, 2);
      core_rdy_for_sn = 4'b1111;
      step();
      chk("t3_next_sel", sn_sel, 3);
      core_rdy_for_sn = '0;

      // Forward mux from core 1.
      do_reset();
      for (int b = 0; b < N; b++) begin
         core_fwd_rd_data[b*DW +: DW]  = {32'hDEADBEEF, 32'(b)};
         core_fwd_byte_len[b*LW +: LW] = 32'(1000 + 100 * b);
      end
      core_rdy_for_fwd = 4'b1010;
      step();
      chk("t4_offer", rdy_for_fwd, 1);
      chk("t4_sel", fwd_sel, 1);
      rdy_for_fwd_ack = 1;
      #1;
      chk("t4_ack", core_rdy_for_fwd_ack, 4'b0010);
      step();
      rdy_for_fwd_ack = 0;
      fwd_rd_en = 1;
      core_fwd_rd_data_vld = 4'b0010;
      #1;
      chk("t4_data", fwd_rd_data, 64'hDEADBEEF_00000001);
      chk("t4_len", fwd_byte_len, 32'd1100);
      chk("t4_vld", fwd_rd_data_vld, 1);
      chk("t4_rd_en", core_fwd_rd_en, 4'b0010);
      fwd_done = 1;
      #1;
      chk("t4_done", core_fwd_done, 4'b0010);
      step();
      fwd_done = 0;
      fwd_rd_en = 0;
      core_rdy_for_fwd = '0;
      #1;
      chk("t4_vld_idle", fwd_rd_data_vld, 0);

      // Asynchronous reset with both sides mid-packet.
      do_reset();
      core_rdy_for_sn  = 4'b0100;
      core_rdy_for_fwd = 4'b1000;
      step();
      rdy_for_sn_ack = 1;
      rdy_for_fwd_ack = 1;
      step();
      rdy_for_sn_ack = 0;
      rdy_for_fwd_ack = 0;
      sn_wr_en = 1;
      sn_done  = 1;
      fwd_rd_en = 1;
      core_fwd_rd_data_vld = 4'b1111;
      #1;
      chk("t5_pre_wr", core_sn_wr_en, 4'b0100);
      chk("t5_pre_vld", fwd_rd_data_vld, 1);
      rst = 1'b1;
      #1;
      chk("t5_wr", core_sn_wr_en, 4'b0000);
      chk("t5_done", core_sn_done, 4'b0000);
      chk("t5_rd", core_fwd_rd_en, 4'b0000);
      chk("t5_vld", fwd_rd_data_vld, 0);
      chk("t5_data", fwd_rd_data, 64'd0);
      chk("t5_sn_sel", sn_sel, 0);
      chk("t5_fwd_sel", fwd_sel, 0);
      clear_inputs();
      step();
      step();
      rst = 1'b0;
      core_rdy_for_sn  = 4'b1111;
      core_rdy_for_fwd = 4'b1111;
      step();
      chk("t5_sn_ptr0", sn_sel, 0);
      chk("t5_fw_ptr0", fwd_sel, 0);
      core_rdy_for_sn  = '0;
      core_rdy_for_fwd = '0;

      // Withdrawal while offered: no ack, pointer unchanged.
      do_reset();
      core_rdy_for_sn = 4'b0001;
      sn_packet(0, 4'b0001, sel);
      core_rdy_for_sn = 4'b0110;
      step();
      chk("t6_sel", sn_sel, 1);
      core_rdy_for_sn = 4'b0001;
      rdy_for_sn_ack = 1;
      #1;
      chk("t6_no_ack", core_rdy_for_sn_ack, 4'b0000);
      step();
      rdy_for_sn_ack = 0;
      core_rdy_for_sn = 4'b0011;
      chk("t6_rdy_fell", rdy_for_sn, 0);
      step();
      chk("t6_reoffer", rdy_for_sn, 1);
      chk("t6_ptr_kept", sn_sel, 1);

      // Random traffic against the model, with occasional async resets.
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         flip = N'($urandom) & N'($urandom) & N'($urandom);
         core_rdy_for_sn ^= flip;
         flip = N'($urandom) & N'($urandom) & N'($urandom);
         core_rdy_for_fwd ^= flip;
         rdy_for_sn_ack  = 1'($urandom_range(0, 1));
         rdy_for_fwd_ack = 1'($urandom_range(0, 1));
         sn_wr_en  = 1'($urandom_range(0, 1));
         fwd_rd_en = 1'($urandom_range(0, 1));
         sn_done   = ($urandom_range(0, 5) == 0);
         fwd_done  = ($urandom_range(0, 5) == 0);
         core_fwd_rd_data_vld = N'($urandom);
         for (int w = 0; w < N*DW/32; w++) core_fwd_rd_data[w*32 +: 32] = $urandom;
         for (int w = 0; w < N; w++) core_fwd_byte_len[w*LW +: LW] = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #4 rst = 1'b0;
         end
         step();
      end

      clear_inputs();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/packet_dispatcher.md
PACKET_DISPATCHER -- requirements
Module: packet_dispatcher

Interface
REQ-001 Parameter N_CORES, default 4: number of packetfilter cores served, 2..16.
REQ-002 Parameter SN_FWD_DATA_WIDTH, default 64: forwarder read-data width.
REQ-003 Parameter PLEN_WIDTH, default 32: packet byte-length width.
REQ-004 clk  in  1  sole clock, all logic posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rdy_for_sn  out  1  a core is offered to the snooper.
REQ-007 rdy_for_sn_ack  in  1  snooper accepts the offered core.
REQ-008 sn_wr_en, sn_done  in  1 each  snooper write strobe and end-of-packet.
REQ-009 core_rdy_for_sn  in  N_CORES  per-core ready-for-snoop.
REQ-010 core_rdy_for_sn_ack, core_sn_wr_en, core_sn_done  out  N_CORES each  routed snoop controls.
REQ-011 rdy_for_fwd  out  1  a core is offered to the forwarder.
REQ-012 rdy_for_fwd_ack  in  1  forwarder accepts the offered core.
REQ-013 fwd_rd_en, fwd_done  in  1 each  forwarder read strobe and end-of-packet.
REQ-014 core_rdy_for_fwd  in  N_CORES  per-core accepted-packet-ready.
REQ-015 core_rdy_for_fwd_ack, core_fwd_rd_en, core_fwd_done  out  N_CORES each  routed forward controls.
REQ-016 core_fwd_rd_data  in  N_CORES*SN_FWD_DATA_WIDTH;  core_fwd_rd_data_vld  in  N_CORES;  core_fwd_byte_len  in  N_CORES*PLEN_WIDTH.
REQ-017 fwd_rd_data  out  SN_FWD_DATA_WIDTH;  fwd_rd_data_vld  out  1;  fwd_byte_len  out  PLEN_WIDTH  muxed from fwd_sel.
REQ-018 sn_sel, fwd_sel  out  CLOG2(N_CORES)  currently granted core index, registered.

Function
REQ-019 Snoop FSM states SN_IDLE, SN_OFFER, SN_BUSY; forward FSM FW_IDLE, FW_OFFER, FW_BUSY; the two run independently.
REQ-020 SN_IDLE: if any core_rdy_for_sn bit set, latch sn_sel = first set bit at or after sn_ptr (round-robin, wrapping at N_CORES-1 -> 0), go SN_OFFER next cycle.
REQ-021 SN_OFFER: rdy_for_sn=1 (registered); on rdy_for_sn_ack, core_rdy_for_sn_ack[sn_sel] pulses exactly one cycle (same cycle, combinational), go SN_BUSY.
REQ-022 SN_BUSY: core_sn_wr_en[sn_sel]=sn_wr_en and core_sn_done[sn_sel]=sn_done combinationally, all other bits 0; on sn_done go SN_IDLE and sn_ptr = sn_sel+1 mod N_CORES.
REQ-023 sn_wr_en, sn_done, rdy_for_sn_ack outside their valid state are ignored; no core strobe asserted.
REQ-024 Forward FSM identical to REQ-020..023 using core_rdy_for_fwd, rdy_for_fwd, rdy_for_fwd_ack, fwd_rd_en, fwd_done, fwd_ptr, fwd_sel.
REQ-025 fwd_rd_data, fwd_rd_data_vld, fwd_byte_len select slice fwd_sel combinationally in FW_BUSY; fwd_rd_data_vld forced 0 otherwise.
REQ-026 Minimum latency core ready -> rdy_for_sn/rdy_for_fwd high: 1 cycle.
REQ-027 A core's ready bit dropping while in OFFER aborts to IDLE without ack; pointer unchanged.
REQ-028 Same core may be granted on both sides simultaneously (different packets, ping-pong buffers); no cross-FSM interlock.
REQ-029 Ack and done in the same cycle in OFFER: ack honoured, done ignored.

Reset
REQ-030 On rst: both FSMs IDLE, sn_ptr=fwd_ptr=0, sn_sel=fwd_sel=0, rdy_for_sn=rdy_for_fwd=0, all per-core outputs 0, fwd_rd_data_vld=0.
REQ-031 Reset mid-packet abandons the transfer; no done pulse is generated to the core.

Structure
REQ-032 State encodings and CLOG2 macro live in the shared header used by parallel_cores.
REQ-033 One sub-module rr_picker (request vector + pointer -> valid + index), instantiated twice.

Verification
REQ-034 Reset, core_rdy_for_sn=4'b0001 -> rdy_for_sn high 1 cycle later; ack -> core_rdy_for_sn_ack=4'b0001 one cycle, sn_sel=0.
REQ-035 core_rdy_for_sn=4'b1111 held, four full snoop packets -> sn_sel sequence 0,1,2,3, then 0 (wrap).
REQ-036 In SN_BUSY sel=2, 8 sn_wr_en pulses -> core_sn_wr_en=4'b0100 each, others 0; sn_done -> SN_IDLE, sn_ptr=3.
REQ-037 core_rdy_for_fwd=4'b1010, ack, fwd_rd_en with core 1 data 64'hDEADBEEF_00000001 -> fwd_rd_data equal, fwd_byte_len = core 1 length.
REQ-038 rst asserted during SN_BUSY and FW_BUSY -> all outputs 0 asynchronously, both pointers 0.
REQ-039 Core deasserts ready while offered -> rdy_for_sn falls next cycle, no ack pulse, next grant starts from unchanged pointer.
